decoder4: RTL and testbench
===========================

// Module: decoder4
//
// PURPOSE
//   Registered 2-to-4 line decoder with enable: a one-hot version of the
//   2-bit select {p,q} appears on y0..y3 when enabled; all outputs go low
//   when disabled.
//   Building block for wider decoders. Two instances plus an inverter on the
//   enable form a 3-to-8 decoder: one instance gets r, the other gets ~r.
//
// PARAMETERS
//   EN_ACTIVE_HIGH  1  1: r=1 enables decoding; 0: r=0 enables decoding
//   OUT_ACTIVE_LOW  0  0: selected output =1, others =0; 1: all polarities inverted
//   REGISTERED      1  1: outputs registered on clk (1-cycle latency); 0: combinational
//
// PORTS
//   clk    input   1  rising-edge clock
//   rst_n  input   1  asynchronous active-low reset
//   y0     output  1  decoded line 0, active for {p,q}=2'b00
//   y1     output  1  decoded line 1, active for {p,q}=2'b01
//   y2     output  1  decoded line 2, active for {p,q}=2'b10
//   y3     output  1  decoded line 3, active for {p,q}=2'b11
//   p      input   1  select bit 1 (MSB)
//   q      input   1  select bit 0 (LSB)
//   r      input   1  enable; polarity set by EN_ACTIVE_HIGH
//   Port order in instantiation: (y0,y1,y2,y3,p,q,r); clk and rst_n are
//   connected by name.
//
// BEHAVIOUR
//   - Enable: en = EN_ACTIVE_HIGH ? r : ~r.
//   - Decode:
//       idx = {p,q}
//       dec[i] = en & (idx == i), for i = 0..3
//       out = OUT_ACTIVE_LOW ? ~dec : dec
//   - REGISTERED=1:
//       - y[3:0] <= out on each rising clk edge; latency is exactly 1 cycle.
//       - rst_n low clears y immediately, regardless of clk: y=4'b0000
//         (4'b1111 if OUT_ACTIVE_LOW), i.e. the inactive level.
//       - Reset release: the first capture happens on the first rising edge
//         with rst_n high.
//       - rst_n asserted mid-operation overrides any pending capture.
//         Outputs stay at the inactive level while rst_n is low.
//   - REGISTERED=0:
//       - y = out combinationally, zero latency.
//       - clk and rst_n are ignored.
//   - Output invariants:
//       - Enabled: exactly one output is at the active level.
//       - Disabled: all four are at the inactive level.
//       - No glitch-free guarantee in combinational mode.
//   - X or Z on p, q or r while enabled: the outputs are don't-care and
//     need not be one-hot. Reset still forces the defined inactive value.
//   - Select and enable changing in the same cycle: the registered output
//     reflects the values sampled at the edge only.
//   - No internal state beyond the 4-bit output register.
//
// TESTING  (defaults unless stated)
//   1. Reset: rst_n=0 with p,q,r=1 and clk running -> y3..y0=0000 at once
//      and held. After release, the next edge gives y3..y0=1000.
//   2. Exhaustive sweep: r=1, {p,q}=00,01,10,11 on successive edges ->
//      y3..y0 = 0001, 0010, 0100, 1000, each one cycle after the input
//      is applied.
//   3. Disable: r=0 for every {p,q} -> y3..y0=0000. Toggling r 1->0 with
//      {p,q}=10 gives 0100 then 0000 on the next edge.
//   4. Async reset mid-run: with y3..y0=0010, drop rst_n between edges ->
//      y3..y0=0000 before the next edge.
//   5. 3-to-8 pairing, EN_ACTIVE_HIGH=1: instance A gets r, instance B gets
//      ~r. Sweep all 8 {p,q,r} -> exactly one of the 8 outputs is high.
//   6. OUT_ACTIVE_LOW=1 and REGISTERED=0, r=1, {p,q}=01 -> y3..y0=1101
//      with zero latency.

Source files
------------

// File: rtl/decoder4.sv
// Registered (or combinational) 2-to-4 line decoder with enable.
// Two instances with complementary enables form a 3-to-8 decoder.
module decoder4 #(
  parameter bit EN_ACTIVE_HIGH = 1'b1,
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REGISTERED     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  input  logic p,
  input  logic q,
  input  logic r
);

  // XOR mask that flips every line when outputs are active-low.
  localparam logic [3:0] INACTIVE = OUT_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic       en;
  logic [1:0] idx;
  logic [3:0] dec;
  logic [3:0] out_v;
  logic [3:0] y_v;

  assign en  = EN_ACTIVE_HIGH ? r : ~r;
  assign idx = {p, q};

  always_comb begin
    dec = 4'b0000;
    if (en) begin
      dec = 4'b0001 << idx;
    end
  end

  assign out_v = dec ^ INACTIVE;

  generate
    if (REGISTERED) begin : g_reg
      logic [3:0] y_q;

      // Reset parks the outputs at the inactive level, not at zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q <= INACTIVE;
        end else begin
          y_q <= out_v;
        end
      end

      assign y_v = y_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign y_v = out_v;
    end
  endgenerate

  assign y0 = y_v[0];
  assign y1 = y_v[1];
  assign y2 = y_v[2];
  assign y3 = y_v[3];

endmodule

// File: tb/tb_decoder4.sv
// Directed bench for decoder4: reset, sweep, disable, async reset,
// 3-to-8 pairing and the active-low combinational variant.
module tb_decoder4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT: defaults ----------------
  logic p = 1'b0, q = 1'b0, r = 1'b0;
  logic y0, y1, y2, y3;
  logic [3:0] y;
  assign y = {y3, y2, y1, y0};

  decoder4 dut (
    .clk(clk), .rst_n(rst_n),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .p(p), .q(q), .r(r)
  );

  // ---------------- 3-to-8 pair ----------------
  logic p8 = 1'b0, q8 = 1'b0, r8 = 1'b0;
  logic r8_n;
  logic [3:0] ya, yb;
  assign r8_n = ~r8;

  decoder4 u_a (
    .clk(clk), .rst_n(rst_n),
    .y0(ya[0]), .y1(ya[1]), .y2(ya[2]), .y3(ya[3]),
    .p(p8), .q(q8), .r(r8)
  );
  decoder4 u_b (
    .clk(clk), .rst_n(rst_n),
    .y0(yb[0]), .y1(yb[1]), .y2(yb[2]), .y3(yb[3]),
    .p(p8), .q(q8), .r(r8_n)
  );

  // ---------------- active-low combinational ----------------
  logic pc = 1'b0, qc = 1'b0, rc = 1'b0;
  logic [3:0] yc;

  decoder4 #(.OUT_ACTIVE_LOW(1'b1), .REGISTERED(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n),
    .y0(yc[0]), .y1(yc[1]), .y2(yc[2]), .y3(yc[3]),
    .p(pc), .q(qc), .r(rc)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur_exp = 4'b0000;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at a negedge; output must hold until the next posedge, then update.
  task automatic step(input string name, input logic sp, input logic sq,
                      input logic sr, input logic [3:0] exp);
    logic [3:0] want;
    p = sp; q = sq; r = sr;
    exp_q.push_back(exp);
    #1 check({name, "_hold"}, {4'b0, y}, {4'b0, cur_exp});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_noexp"}, 8'd1, 8'd0);
    end else begin
      want = exp_q.pop_front();
      check(name, {4'b0, y}, {4'b0, want});
      cur_exp = want;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic       p;
    logic       q;
    logic       r;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'b1000};  // first capture after reset
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'b0001};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'b0010};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'b0100};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'b1000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'b0100};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'b0000};  // r 1->0 with {p,q}=10
    vecs[11] = '{1'b0, 1'b1, 1'b1, 4'b0010};

    // Reset with all selects/enable high, clock running.
    p = 1'b1; q = 1'b1; r = 1'b1;
    pc = 1'b0; qc = 1'b1; rc = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_immediate", {4'b0, y}, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", {4'b0, y}, 8'h00);
      check("reset_pair", {ya, yb}, 8'h00);
    end
    check("comb_ignores_rst", {4'b0, yc}, 8'b0000_1101);

    // Release at a negedge; the vector table starts with the 1000 capture.
    rst_n = 1'b1;
    cur_exp = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].p, vecs[i].q, vecs[i].r, vecs[i].exp);
    end

    // Async reset between edges with y=0010.
    check("pre_async", {4'b0, y}, 8'b0000_0010);
    #2 rst_n = 1'b0;
    #1 check("async_mid", {4'b0, y}, 8'h00);
    p = 1'b1; q = 1'b1; r = 1'b1;
    @(posedge clk);
    #1 check("reset_override", {4'b0, y}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cur_exp = 4'b0000;
    step("post_reset", 1'b0, 1'b0, 1'b1, 4'b0001);

    // 3-to-8 pairing: {r,p,q} indexes the 8 lines {ya,yb}.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] sel;
      logic [7:0] exp8;
      sel = i[2:0];
      p8 = sel[1]; q8 = sel[0]; r8 = sel[2];
      exp8 = 8'b0000_0001 << sel;
      @(posedge clk);
      #1;
      check($sformatf("pair_onehot%0d", i), 8'($countones({ya, yb})), 8'd1);
      check($sformatf("pair_map%0d", i), {ya, yb}, exp8);
      @(negedge clk);
    end

    // Active-low combinational: zero latency.
    pc = 1'b0; qc = 1'b1; rc = 1'b1;
    #1 check("comb_01", {4'b0, yc}, 8'b0000_1101);
    pc = 1'b1; qc = 1'b1;
    #1 check("comb_11", {4'b0, yc}, 8'b0000_0111);
    pc = 1'b0; qc = 1'b0;
    #1 check("comb_00", {4'b0, yc}, 8'b0000_1110);
    rc = 1'b0;
    #1 check("comb_dis", {4'b0, yc}, 8'b0000_1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
